// File: rtl/ame_num_divide_pkg.sv
// Shared definitions for the AME parameter solver divider: operand indices,
// FSM state encoding and the bit-counter width helper.
package ame_pkg;

   localparam int unsigned DIV_NUM = 0;
   localparam int unsigned DIV_DEN = 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } ame_div_state_t;

   function automatic int unsigned div_cnt_bits(input int unsigned data_bits);
      return $clog2(data_bits + 1);
   endfunction

endpackage

// File: rtl/ame_num_divide_if.sv
// Init/done handshake and operand/result bundle of the AME divider.
interface ame_num_divide_if #(
   parameter int unsigned COMP_DATA_BITS = 64
);
   logic                           div_init_i;
   logic [1:0][COMP_DATA_BITS-1:0] div_data_i;
   logic                           div_busy_o;
   logic                           div_done_o;
   logic [COMP_DATA_BITS-1:0]      div_quot_o;
   logic [COMP_DATA_BITS-1:0]      div_rem_o;
   logic                           div_dz_o;
   logic                           div_ovf_o;

   modport master (
      output div_init_i, div_data_i,
      input  div_busy_o, div_done_o, div_quot_o, div_rem_o, div_dz_o, div_ovf_o
   );

   modport slave (
      input  div_init_i, div_data_i,
      output div_busy_o, div_done_o, div_quot_o, div_rem_o, div_dz_o, div_ovf_o
   );
endinterface

// File: rtl/ame_num_divide_step.sv
// One restoring-division iteration: shift {rem, dividend} left and trial-subtract
// the divisor magnitude. The quotient bit enters the dividend LSB.
module ame_num_divide_step #(
   parameter int unsigned W = 64
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] dvd_i,
   input  logic [W:0]   den_i,
   output logic [W-1:0] rem_o,
   output logic [W-1:0] dvd_o
);
   logic [W:0] shifted;
   logic [W:0] diff;

   // rem < |DEN| <= 2^(W-1) keeps shifted below 2^W, so diff[W] is a true sign bit.
   always_comb begin
      shifted = {rem_i, dvd_i[W-1]};
      diff    = shifted - den_i;
      rem_o   = diff[W] ? shifted[W-1:0] : diff[W-1:0];
      dvd_o   = {dvd_i[W-2:0], ~diff[W]};
   end
endmodule

// File: rtl/ame_num_divide.sv
// Bit-serial signed restoring divider: NUM / DEN with truncation toward zero,
// constant latency, single-cycle done pulse and dz/ovf flags.
module ame_num_divide
   import ame_pkg::*;
#(
   parameter int unsigned COMP_DATA_BITS = 64
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   ame_num_divide_if.slave    div_if
);
   localparam int unsigned N  = COMP_DATA_BITS;
   localparam int unsigned CW = div_cnt_bits(COMP_DATA_BITS);

   ame_div_state_t state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   rem_q, rem_d;
   logic [N-1:0]   dvd_q, dvd_d;
   logic [N:0]     den_q, den_d;
   logic [N-1:0]   num_q, num_d;
   logic           qneg_q, qneg_d, rneg_q, rneg_d;
   logic           dz_q, dz_d, ovf_q, ovf_d;
   logic [N-1:0]   quot_o_q, quot_o_d, rem_o_q, rem_o_d;
   logic           dz_o_q, dz_o_d, ovf_o_q, ovf_o_d, done_q, done_d;

   logic [N-1:0]   num_s, num_mag, step_rem, step_dvd;
   logic [N-1:0]   den_s;
   logic [N:0]     den_mag;

   ame_num_divide_step #(.W(N)) u_step (
      .rem_i (rem_q),
      .dvd_i (dvd_q),
      .den_i (den_q),
      .rem_o (step_rem),
      .dvd_o (step_dvd)
   );

   // N-bit negation of MIN yields 2^(N-1) as an unsigned magnitude, which is exact.
   always_comb begin
      num_s   = div_if.div_data_i[DIV_NUM];
      den_s   = div_if.div_data_i[DIV_DEN];
      num_mag = num_s[N-1] ? -num_s : num_s;
      den_mag = den_s[N-1] ? -{1'b1, den_s} : {1'b0, den_s};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      den_d    = den_q;
      num_d    = num_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      quot_o_d = '0;
      rem_o_d  = '0;
      dz_o_d   = 1'b0;
      ovf_o_d  = 1'b0;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (div_if.div_init_i) begin
               dvd_d   = num_mag;
               den_d   = den_mag;
               num_d   = num_s;
               qneg_d  = num_s[N-1] ^ den_s[N-1];
               rneg_d  = num_s[N-1];
               dz_d    = (den_s == '0);
               ovf_d   = (num_s == {1'b1, {(N-1){1'b0}}}) && (den_s == '1);
               rem_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            rem_d = step_rem;
            dvd_d = step_dvd;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            done_d  = 1'b1;
            dz_o_d  = dz_q;
            ovf_o_d = ovf_q;
            if (dz_q) begin
               rem_o_d = num_q;
            end else if (ovf_q) begin
               quot_o_d = {1'b0, {(N-1){1'b1}}};
            end else begin
               quot_o_d = qneg_q ? -dvd_q : dvd_q;
               rem_o_d  = rneg_q ? -rem_q : rem_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         den_q    <= '0;
         num_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         quot_o_q <= '0;
         rem_o_q  <= '0;
         dz_o_q   <= 1'b0;
         ovf_o_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         den_q    <= den_d;
         num_q    <= num_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
         quot_o_q <= quot_o_d;
         rem_o_q  <= rem_o_d;
         dz_o_q   <= dz_o_d;
         ovf_o_q  <= ovf_o_d;
         done_q   <= done_d;
      end
   end

   assign div_if.div_busy_o = (state_q != IDLE);
   assign div_if.div_done_o = done_q;
   assign div_if.div_quot_o = quot_o_q;
   assign div_if.div_rem_o  = rem_o_q;
   assign div_if.div_dz_o   = dz_o_q;
   assign div_if.div_ovf_o  = ovf_o_q;
endmodule

// File: tb/tb_ame_num_divide.sv
// Self-checking bench for ame_num_divide against a truncating signed-division model.
module tb_ame_num_divide;
   localparam int unsigned N    = 64;
   localparam int          LAT  = N + 1;
   localparam longint      MINV = 64'sh8000_0000_0000_0000;
   localparam longint      MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   ame_num_divide_if #(.COMP_DATA_BITS(N)) dif ();

   ame_num_divide #(.COMP_DATA_BITS(N)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .div_if  (dif.slave)
   );

   function automatic void model(input longint n, input longint d, output longint q,
                                 output longint r, output logic dz, output logic ovf);
      dz = 1'b0; ovf = 1'b0;
      if (d == 0) begin
         q = 0; r = n; dz = 1'b1;
      end else if (n == MINV && d == -1) begin
         q = MAXV; r = 0; ovf = 1'b1;
      end else begin
         q = n / d; r = n % d;
      end
   endfunction

   // Drives one operation, optionally re-pulsing init at cycle inj_j, and records what came out.
   task automatic run_op(input longint num, input longint den, input int inj_j,
                         input longint inj_num, input longint inj_den,
                         output longint q, output longint r, output logic dz, output logic ovf,
                         output int lat, output int busy_cnt, output int done_cnt, output int idle_nz);
      lat = -1; busy_cnt = 0; done_cnt = 0; idle_nz = 0;
      q = 0; r = 0; dz = 1'b0; ovf = 1'b0;
      @(negedge clk);
      dif.div_init_i = 1'b1;
      dif.div_data_i[0] = num;
      dif.div_data_i[1] = den;
      for (int j = 0; j < LAT + 8; j++) begin
         @(negedge clk);
         dif.div_init_i = (j == inj_j);
         if (j == inj_j) begin
            dif.div_data_i[0] = inj_num;
            dif.div_data_i[1] = inj_den;
         end
         if (dif.div_busy_o) busy_cnt++;
         if (dif.div_done_o) begin
            done_cnt++;
            if (lat < 0) begin
               lat = j;
               q = $signed(dif.div_quot_o);
               r = $signed(dif.div_rem_o);
               dz = dif.div_dz_o;
               ovf = dif.div_ovf_o;
            end
         end else if (dif.div_quot_o != 0 || dif.div_rem_o != 0 || dif.div_dz_o || dif.div_ovf_o) begin
            idle_nz++;
         end
      end
      dif.div_init_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      dif.div_init_i = 1'b0;
      dif.div_data_i = '0;
      repeat (3) @(negedge clk);
      tests++;
      if (dif.div_busy_o !== 1'b0 || dif.div_done_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", dif.div_busy_o, dif.div_done_o);
      end
      tests++;
      if (dif.div_quot_o !== '0 || dif.div_rem_o !== '0 || dif.div_dz_o !== 1'b0 || dif.div_ovf_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_data: quot=%h rem=%h dz=%b ovf=%b, required all 0",
                  dif.div_quot_o, dif.div_rem_o, dif.div_dz_o, dif.div_ovf_o);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      longint q, r; logic dz, ovf; int lat, bc, dc, nz;
      run_op(100, 7, -1, 0, 0, q, r, dz, ovf, lat, bc, dc, nz);
      tests++;
      if (q !== 14 || r !== 2 || dz !== 1'b0 || ovf !== 1'b0) begin
         fails++;
         $display("FAIL basic_result: q=%0d r=%0d dz=%b ovf=%b, required 14 2 0 0", q, r, dz, ovf);
      end
      tests++;
      if (lat !== LAT || dc !== 1) begin
         fails++;
         $display("FAIL basic_latency: lat=%0d dones=%0d, required %0d 1", lat, dc, LAT);
      end
      tests++;
      if (bc !== LAT) begin
         fails++;
         $display("FAIL basic_busy: busy cycles=%0d, required %0d", bc, LAT);
      end
      tests++;
      if (nz !== 0) begin
         fails++;
         $display("FAIL basic_hold: nonzero outputs outside done in %0d cycles, required 0", nz);
      end
   endtask

   task automatic test_signs();
      longint nums[3] = '{-100, 100, -100};
      longint dens[3] = '{7, -7, -7};
      longint eq[3]   = '{-14, -14, 14};
      longint er[3]   = '{-2, 2, -2};
      longint q, r; logic dz, ovf; int lat, bc, dc, nz;
      for (int i = 0; i < 3; i++) begin
         run_op(nums[i], dens[i], -1, 0, 0, q, r, dz, ovf, lat, bc, dc, nz);
         tests++;
         if (q !== eq[i] || r !== er[i] || dz || ovf) begin
            fails++;
            $display("FAIL signs_%0d: q=%0d r=%0d dz=%b ovf=%b, required %0d %0d 0 0",
                     i, q, r, dz, ovf, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_min();
      longint q, r; logic dz, ovf; int lat, bc, dc, nz;
      run_op(MINV, -1, -1, 0, 0, q, r, dz, ovf, lat, bc, dc, nz);
      tests++;
      if (q !== MAXV || r !== 0 || dz !== 1'b0 || ovf !== 1'b1 || lat !== LAT) begin
         fails++;
         $display("FAIL min_ovf: q=%h r=%0d dz=%b ovf=%b lat=%0d, required %h 0 0 1 %0d",
                  q, r, dz, ovf, lat, MAXV, LAT);
      end
      run_op(MINV, 2, -1, 0, 0, q, r, dz, ovf, lat, bc, dc, nz);
      tests++;
      if (q !== 64'shC000_0000_0000_0000 || r !== 0 || dz || ovf) begin
         fails++;
         $display("FAIL min_div2: q=%h r=%0d dz=%b ovf=%b, required c000000000000000 0 0 0",
                  q, r, dz, ovf);
      end
   endtask

   task automatic test_div_zero();
      longint q, r; logic dz, ovf; int lat, bc, dc, nz;
      run_op(55, 0, -1, 0, 0, q, r, dz, ovf, lat, bc, dc, nz);
      tests++;
      if (q !== 0 || r !== 55 || dz !== 1'b1 || ovf !== 1'b0) begin
         fails++;
         $display("FAIL dz_result: q=%0d r=%0d dz=%b ovf=%b, required 0 55 1 0", q, r, dz, ovf);
      end
      tests++;
      if (lat !== LAT || bc !== LAT) begin
         fails++;
         $display("FAIL dz_latency: lat=%0d busy=%0d, required %0d %0d", lat, bc, LAT, LAT);
      end
   endtask

   task automatic test_busy_init();
      longint q, r; logic dz, ovf; int lat, bc, dc, nz;
      run_op(1000, 33, 10, 5, 1, q, r, dz, ovf, lat, bc, dc, nz);
      tests++;
      if (q !== 30 || r !== 10 || dz || ovf) begin
         fails++;
         $display("FAIL busy_ignore: q=%0d r=%0d, required 30 10", q, r);
      end
      tests++;
      if (dc !== 1 || lat !== LAT) begin
         fails++;
         $display("FAIL busy_single_done: dones=%0d lat=%0d, required 1 %0d", dc, lat, LAT);
      end
   endtask

   task automatic test_back_to_back();
      longint qa, qb, eq, er; logic dzm, ovfm;
      int j, lat_b;
      logic seen;
      @(negedge clk);
      dif.div_init_i = 1'b1;
      dif.div_data_i[0] = 64'sd12345;
      dif.div_data_i[1] = -64'sd100;
      @(negedge clk);
      dif.div_init_i = 1'b0;
      seen = 1'b0;
      qa = 0;
      for (j = 0; j < LAT + 8 && !seen; j++) begin
         @(negedge clk);
         if (dif.div_done_o) begin
            seen = 1'b1;
            qa = $signed(dif.div_quot_o);
            dif.div_init_i = 1'b1;
            dif.div_data_i[0] = -64'sd999;
            dif.div_data_i[1] = 64'sd10;
         end
      end
      tests++;
      if (!seen || qa !== -123) begin
         fails++;
         $display("FAIL b2b_first: seen=%b q=%0d, required 1 -123", seen, qa);
      end
      lat_b = -1;
      qb = 0;
      for (int k = 0; k < LAT + 8; k++) begin
         @(negedge clk);
         dif.div_init_i = 1'b0;
         if (dif.div_done_o && lat_b < 0) begin
            lat_b = k;
            qb = $signed(dif.div_quot_o);
            er = $signed(dif.div_rem_o);
         end
      end
      model(-999, 10, eq, qa, dzm, ovfm);
      tests++;
      if (lat_b !== LAT || qb !== eq || er !== qa) begin
         fails++;
         $display("FAIL b2b_second: lat=%0d q=%0d r=%0d, required %0d %0d %0d", lat_b, qb, er, LAT, eq, qa);
      end
   endtask

   task automatic test_reset_mid();
      int dones;
      longint q, r, eq, er; logic dz, ovf, edz, eovf; int lat, bc, dc, nz;
      @(negedge clk);
      dif.div_init_i = 1'b1;
      dif.div_data_i[0] = 64'sd777;
      dif.div_data_i[1] = 64'sd3;
      @(negedge clk);
      dif.div_init_i = 1'b0;
      repeat (29) @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests++;
      if (dif.div_busy_o !== 1'b0 || dif.div_done_o !== 1'b0 || dif.div_quot_o !== '0 ||
          dif.div_rem_o !== '0 || dif.div_dz_o !== 1'b0 || dif.div_ovf_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_outputs: busy=%b done=%b quot=%h rem=%h, required all 0",
                  dif.div_busy_o, dif.div_done_o, dif.div_quot_o, dif.div_rem_o);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < LAT + 10; k++) begin
         @(negedge clk);
         if (dif.div_done_o || dif.div_busy_o) dones++;
      end
      tests++;
      if (dones !== 0) begin
         fails++;
         $display("FAIL reset_mid_abort: busy/done cycles after reset=%0d, required 0", dones);
      end
      run_op(-778, 3, -1, 0, 0, q, r, dz, ovf, lat, bc, dc, nz);
      model(-778, 3, eq, er, edz, eovf);
      tests++;
      if (q !== eq || r !== er || lat !== LAT) begin
         fails++;
         $display("FAIL reset_mid_recover: q=%0d r=%0d lat=%0d, required %0d %0d %0d", q, r, lat, eq, er, LAT);
      end
   endtask

   task automatic test_random();
      longint n, d, q, r, eq, er; logic dz, ovf, edz, eovf; int lat, bc, dc, nz;
      for (int i = 0; i < 600; i++) begin
         n = {$urandom, $urandom};
         d = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: d = longint'($urandom_range(0, 2000)) - 1000;
            1: begin n = longint'($urandom_range(0, 20000)) - 10000; d = longint'($urandom_range(0, 200)) - 100; end
            2: n = MINV;
            3: d = (d >>> $urandom_range(0, 62));
            4: d = (i % 7 == 0) ? 0 : ((i % 5 == 0) ? -1 : d);
            default: ;
         endcase
         run_op(n, d, -1, 0, 0, q, r, dz, ovf, lat, bc, dc, nz);
         model(n, d, eq, er, edz, eovf);
         tests++;
         if (q !== eq || r !== er || dz !== edz || ovf !== eovf || lat !== LAT || dc !== 1 || nz !== 0) begin
            fails++;
            $display("FAIL random_%0d: n=%0d d=%0d got q=%0d r=%0d dz=%b ovf=%b lat=%0d dones=%0d nz=%0d, required q=%0d r=%0d dz=%b ovf=%b lat=%0d",
                     i, n, d, q, r, dz, ovf, lat, dc, nz, eq, er, edz, eovf, LAT);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_min();
      test_div_zero();
      test_busy_init();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
